// File: rtl/sample_fetch_ctrl.sv
// Playback sequencer: fetches one 32-bit flash word per pair of sample ticks over Avalon-MM
// and emits it as two 16-bit samples (low half first), walking start_addr..end_addr.
module sample_fetch_ctrl #(
  parameter int ADDR_W = 23,
  parameter bit LOOP   = 1'b1
) (
  input  logic              main_clock,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              restart,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              done,
  output logic              overrun,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EMIT_LO,
    HOLD_HI
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       hi_half;
  logic              restart_pend;
  logic              stopped;

  // The address register doubles as the Avalon address, so it stays stable across a stall.
  assign flash_address = addr;
  assign busy          = (state != IDLE);

  // NOTE: all state below is sequential; non-blocking assignments keep every register
  // updating from the same pre-edge values regardless of statement order.
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr         <= '0;
      hi_half      <= '0;
      restart_pend <= 1'b0;
      stopped      <= 1'b0;
      flash_read   <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;

      case (state)
        IDLE: begin
          if (restart) begin
            addr    <= start_addr;
            stopped <= 1'b0;
          end
          if (play && sample_tick && (restart || !stopped)) begin
            flash_read <= 1'b1;
            state      <= REQ;
          end
        end

        REQ: begin
          if (sample_tick) overrun <= 1'b1;
          if (restart) restart_pend <= 1'b1;
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            state      <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (sample_tick) overrun <= 1'b1;
          if (restart) restart_pend <= 1'b1;
          if (flash_readdatavalid) begin
            hi_half <= flash_readdata[31:16];
            state   <= EMIT_LO;
            // A pending restart discards the whole word, so the low half is never shown.
            if (!(restart_pend || restart)) begin
              sample_out   <= flash_readdata[15:0];
              sample_valid <= 1'b1;
            end
          end
        end

        EMIT_LO: begin
          if (sample_tick) overrun <= 1'b1;
          if (restart_pend || restart) begin
            addr         <= start_addr;
            restart_pend <= 1'b0;
            stopped      <= 1'b0;
            state        <= IDLE;
          end else begin
            state <= HOLD_HI;
          end
        end

        HOLD_HI: begin
          if (restart) begin
            addr    <= start_addr;
            stopped <= 1'b0;
            state   <= IDLE;
          end else if (play && sample_tick) begin
            sample_out   <= hi_half;
            sample_valid <= 1'b1;
            state        <= IDLE;
            // >= rather than == also terminates a range given with start_addr > end_addr.
            if (addr >= end_addr) begin
              addr <= start_addr;
              done <= 1'b1;
              if (!LOOP) stopped <= 1'b1;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_fetch_ctrl.sv
// Directed bench for sample_fetch_ctrl: a looping instance and a stop-at-end instance share
// one flash responder; sel picks which instance the responder and the monitors follow.
module tb_sample_fetch_ctrl;

  localparam int AW = 23;

  logic          main_clock = 1'b0;
  logic          reset_n;
  logic          sample_tick;
  logic          restart;
  logic          play_a;
  logic          play_b;
  logic          sel;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          flash_waitrequest;
  logic [31:0]   flash_readdata;
  logic          flash_readdatavalid;

  logic          fr_a, sv_a, dn_a, ov_a, by_a;
  logic [AW-1:0] fa_a;
  logic [15:0]   so_a;
  logic          fr_b, sv_b, dn_b, ov_b, by_b;
  logic [AW-1:0] fa_b;
  logic [15:0]   so_b;

  logic          fr, sv, dn, ov, by;
  logic [AW-1:0] fa;
  logic [15:0]   so;

  assign fr = sel ? fr_b : fr_a;
  assign fa = sel ? fa_b : fa_a;
  assign so = sel ? so_b : so_a;
  assign sv = sel ? sv_b : sv_a;
  assign dn = sel ? dn_b : dn_a;
  assign ov = sel ? ov_b : ov_a;
  assign by = sel ? by_b : by_a;

  sample_fetch_ctrl #(.ADDR_W(AW), .LOOP(1'b1)) dut (
    .main_clock          (main_clock),
    .reset_n             (reset_n),
    .sample_tick         (sample_tick),
    .play                (play_a),
    .restart             (restart),
    .start_addr          (start_addr),
    .end_addr            (end_addr),
    .flash_read          (fr_a),
    .flash_address       (fa_a),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .sample_out          (so_a),
    .sample_valid        (sv_a),
    .done                (dn_a),
    .overrun             (ov_a),
    .busy                (by_a)
  );

  sample_fetch_ctrl #(.ADDR_W(AW), .LOOP(1'b0)) dut_stop (
    .main_clock          (main_clock),
    .reset_n             (reset_n),
    .sample_tick         (sample_tick),
    .play                (play_b),
    .restart             (restart),
    .start_addr          (start_addr),
    .end_addr            (end_addr),
    .flash_read          (fr_b),
    .flash_address       (fa_b),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .sample_out          (so_b),
    .sample_valid        (sv_b),
    .done                (dn_b),
    .overrun             (ov_b),
    .busy                (by_b)
  );

  always #5 main_clock = ~main_clock;

  int            checks = 0;
  int            failures = 0;

  logic [15:0]   samples[$];
  logic [AW-1:0] reads[$];
  logic [AW-1:0] req_addrs[$];
  int            done_cnt, done_at, ov_cnt;
  int            stall_left = 0;
  int            latency = 1;
  int            lat_cnt;
  logic [AW-1:0] pend_addr;

  // Flash content: high half 0xB0nn, low half 0xA0nn, nn = low address byte.
  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return {8'hB0, a[7:0], 8'hA0, a[7:0]};
  endfunction

  // Flash responder: waitrequest/readdatavalid change on the falling edge only.
  initial begin
    flash_waitrequest   = 1'b0;
    flash_readdatavalid = 1'b0;
    flash_readdata      = '0;
    lat_cnt             = 0;
    pend_addr           = '0;
    forever begin
      @(negedge main_clock);
      flash_readdatavalid = 1'b0;
      if (!reset_n) begin
        lat_cnt           = 0;
        flash_waitrequest = 1'b0;
      end else begin
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            flash_readdatavalid = 1'b1;
            flash_readdata      = word_of(pend_addr);
          end
        end
        if (fr) begin
          req_addrs.push_back(fa);
          if (stall_left > 0) begin
            flash_waitrequest = 1'b1;
            stall_left--;
          end else begin
            flash_waitrequest = 1'b0;
            reads.push_back(fa);
            pend_addr = fa;
            lat_cnt   = latency;
          end
        end else begin
          flash_waitrequest = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge main_clock);
      if (reset_n) begin
        if (sv) samples.push_back(so);
        if (dn) begin
          done_cnt++;
          done_at = samples.size();
        end
        if (ov) ov_cnt++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge main_clock);
  endtask

  task automatic pulse_tick();
    @(negedge main_clock);
    sample_tick = 1'b1;
    @(negedge main_clock);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge main_clock);
    restart = 1'b1;
    @(negedge main_clock);
    restart = 1'b0;
  endtask

  task automatic clear_logs();
    samples.delete();
    reads.delete();
    req_addrs.delete();
    done_cnt = 0;
    done_at  = -1;
    ov_cnt   = 0;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    restart     = 1'b0;
    play_a      = 1'b0;
    play_b      = 1'b0;
    sel         = 1'b0;
    start_addr  = 23'h10;
    end_addr    = 23'h11;
    wait_cycles(3);
    checks++; if (fr !== 1'b0)  begin failures++; $display("FAIL reset_flash_read got=%b exp=0", fr); end
    checks++; if (fa !== '0)    begin failures++; $display("FAIL reset_address got=%h exp=0", fa); end
    checks++; if (so !== 16'h0) begin failures++; $display("FAIL reset_sample_out got=%h exp=0", so); end
    checks++; if ({sv, dn, ov} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {sv, dn, ov}); end
    checks++; if (by !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", by); end
    reset_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_playback();
    logic [15:0]   exp_s[6] = '{16'hA010, 16'hB010, 16'hA011, 16'hB011, 16'hA010, 16'hB010};
    logic [AW-1:0] exp_r[3] = '{23'h10, 23'h11, 23'h10};
    clear_logs();
    pulse_restart();
    play_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse_tick();
      wait_cycles(49);
    end
    checks++; if (reads.size() !== 3) begin failures++; $display("FAIL play_read_count got=%0d exp=3", reads.size()); end
    for (int i = 0; i < 3 && i < reads.size(); i++) begin
      checks++; if (reads[i] !== exp_r[i]) begin failures++; $display("FAIL play_read_addr[%0d] got=%h exp=%h", i, reads[i], exp_r[i]); end
    end
    checks++; if (samples.size() !== 6) begin failures++; $display("FAIL play_sample_count got=%0d exp=6", samples.size()); end
    for (int i = 0; i < 6 && i < samples.size(); i++) begin
      checks++; if (samples[i] !== exp_s[i]) begin failures++; $display("FAIL play_sample[%0d] got=%h exp=%h", i, samples[i], exp_s[i]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL play_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_at !== 4)  begin failures++; $display("FAIL play_done_position got=%0d exp=4", done_at); end
    checks++; if (ov_cnt !== 0)   begin failures++; $display("FAIL play_overrun got=%0d exp=0", ov_cnt); end
    checks++; if (by !== 1'b0)    begin failures++; $display("FAIL play_busy_idle got=%b exp=0", by); end
  endtask

  task automatic test_waitrequest();
    logic addr_ok;
    clear_logs();
    stall_left = 5;
    pulse_tick();
    checks++; if (fr !== 1'b1) begin failures++; $display("FAIL stall_read_latency got=%b exp=1", fr); end
    wait_cycles(30);
    checks++; if (req_addrs.size() !== 6) begin failures++; $display("FAIL stall_req_cycles got=%0d exp=6", req_addrs.size()); end
    addr_ok = 1'b1;
    foreach (req_addrs[i]) if (req_addrs[i] !== 23'h11) addr_ok = 1'b0;
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL stall_addr_stable got=%b exp=1", addr_ok); end
    checks++; if (reads.size() !== 1) begin failures++; $display("FAIL stall_single_read got=%0d exp=1", reads.size()); end
    pulse_tick();
    wait_cycles(5);
    checks++; if (samples.size() !== 2) begin failures++; $display("FAIL stall_sample_count got=%0d exp=2", samples.size()); end
    if (samples.size() == 2) begin
      checks++; if (samples[0] !== 16'hA011) begin failures++; $display("FAIL stall_lo got=%h exp=A011", samples[0]); end
      checks++; if (samples[1] !== 16'hB011) begin failures++; $display("FAIL stall_hi got=%h exp=B011", samples[1]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_overrun();
    clear_logs();
    latency = 60;
    pulse_tick();
    wait_cycles(10);
    pulse_tick();
    wait_cycles(80);
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt); end
    checks++; if (samples.size() !== 1) begin failures++; $display("FAIL ovr_lo_only got=%0d exp=1", samples.size()); end
    latency = 1;
    pulse_tick();
    wait_cycles(5);
    checks++; if (reads.size() !== 1) begin failures++; $display("FAIL ovr_no_extra_read got=%0d exp=1", reads.size()); end
    checks++; if (samples.size() !== 2) begin failures++; $display("FAIL ovr_sample_count got=%0d exp=2", samples.size()); end
    if (samples.size() == 2) begin
      checks++; if (samples[0] !== 16'hA010) begin failures++; $display("FAIL ovr_lo got=%h exp=A010", samples[0]); end
      checks++; if (samples[1] !== 16'hB010) begin failures++; $display("FAIL ovr_hi got=%h exp=B010", samples[1]); end
    end
  endtask

  task automatic test_pause();
    clear_logs();
    pulse_tick();
    wait_cycles(20);
    play_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      wait_cycles(20);
    end
    checks++; if (samples.size() !== 1) begin failures++; $display("FAIL pause_no_emit got=%0d exp=1", samples.size()); end
    checks++; if (by !== 1'b1) begin failures++; $display("FAIL pause_busy got=%b exp=1", by); end
    play_a = 1'b1;
    pulse_tick();
    wait_cycles(5);
    checks++; if (samples.size() !== 2) begin failures++; $display("FAIL pause_resume_count got=%0d exp=2", samples.size()); end
    if (samples.size() == 2) begin
      checks++; if (samples[1] !== 16'hB011) begin failures++; $display("FAIL pause_resume_hi got=%h exp=B011", samples[1]); end
    end
    checks++; if (reads.size() !== 1) begin failures++; $display("FAIL pause_reads got=%0d exp=1", reads.size()); end
  endtask

  task automatic test_restart_wait();
    clear_logs();
    latency    = 30;
    start_addr = 23'h30;
    end_addr   = 23'h31;
    pulse_tick();
    wait_cycles(5);
    pulse_restart();
    wait_cycles(50);
    checks++; if (samples.size() !== 0) begin failures++; $display("FAIL rst_discard got=%0d exp=0", samples.size()); end
    checks++; if (by !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b exp=0", by); end
    pulse_tick();
    wait_cycles(40);
    checks++; if (reads.size() !== 2) begin failures++; $display("FAIL rst_read_count got=%0d exp=2", reads.size()); end
    if (reads.size() == 2) begin
      checks++; if (reads[0] !== 23'h10) begin failures++; $display("FAIL rst_first_read got=%h exp=10", reads[0]); end
      checks++; if (reads[1] !== 23'h30) begin failures++; $display("FAIL rst_reload_read got=%h exp=30", reads[1]); end
    end
    checks++; if (samples.size() !== 1) begin failures++; $display("FAIL rst_new_sample got=%0d exp=1", samples.size()); end
    if (samples.size() == 1) begin
      checks++; if (samples[0] !== 16'hA030) begin failures++; $display("FAIL rst_new_lo got=%h exp=A030", samples[0]); end
    end
    play_a  = 1'b0;
    latency = 1;
  endtask

  task automatic test_stop_mode();
    sel        = 1'b1;
    start_addr = 23'h20;
    end_addr   = 23'h20;
    clear_logs();
    pulse_restart();
    play_b = 1'b1;
    pulse_tick();
    wait_cycles(20);
    pulse_tick();
    wait_cycles(5);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      wait_cycles(30);
    end
    checks++; if (reads.size() !== 1) begin failures++; $display("FAIL stop_single_read got=%0d exp=1", reads.size()); end
    if (reads.size() == 1) begin
      checks++; if (reads[0] !== 23'h20) begin failures++; $display("FAIL stop_read_addr got=%h exp=20", reads[0]); end
    end
    checks++; if (samples.size() !== 2) begin failures++; $display("FAIL stop_samples got=%0d exp=2", samples.size()); end
    if (samples.size() == 2) begin
      checks++; if (samples[1] !== 16'hB020) begin failures++; $display("FAIL stop_hi got=%h exp=B020", samples[1]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stop_done got=%0d exp=1", done_cnt); end
    checks++; if (by !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", by); end

    pulse_restart();
    stall_left = 10;
    pulse_tick();
    @(negedge main_clock);
    checks++; if (fr !== 1'b1) begin failures++; $display("FAIL stop_restart_read got=%b exp=1", fr); end
    checks++; if (reads.size() !== 1) begin failures++; $display("FAIL stop_stalled_reads got=%0d exp=1", reads.size()); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (fr !== 1'b0) begin failures++; $display("FAIL async_reset_read got=%b exp=0", fr); end
    checks++; if (by !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", by); end
    stall_left = 0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(2);
  endtask

  initial begin
    test_reset();
    test_playback();
    test_waitrequest();
    test_overrun();
    test_pause();
    test_restart_wait();
    test_stop_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
